regwb_scheduler: RTL
====================

# regwb_scheduler

Write-port scheduler and FP scoreboard sitting between the core datapath, the multi-cycle FPU, and the dual-file (integer/FP) register file. It shares the register file's single write port between single-cycle core results and long-latency FPU completions. It tracks FP destinations with outstanding long operations and stalls the core on RAW/WAW hazards, write-port loss or scoreboard overflow. Its write-port outputs drive the register file's write-enable, FP-select, double and write-address/data inputs directly.

## Interface
- MAX_OUT, 4: maximum outstanding long FPU operations (1..15)
- AGE_LIMIT, 3: cycles a pending FPU completion may lose arbitration before it wins (with guard compiled in)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ins_valid  in  1  core presents an instruction this cycle
- ins_regwrite  in  1  instruction writes a register
- ins_long  in  1  instruction dispatches to FPU (result returns later)
- ins_fp, ins_double  in  1 each  destination is FP; destination is a pair
- ins_dst, ins_src0, ins_src1  in  5 each  register indices
- ins_src_fp0, ins_src_fp1, ins_src_dbl  in  1 each  source files; sources are pairs
- ins_wdata0, ins_wdata1  in  32 each  single-cycle result words
- fpu_valid  in  1  FPU completion pending
- fpu_dst  in  5 / fpu_double in 1 / fpu_data0, fpu_data1 in 32  completion payload
- fpu_ready  out  1  completion accepted this cycle
- stall  out  1  core must hold PC and instruction
- rf_we, rf_fp, rf_double  out  1 each  register-file write controls
- rf_waddr  out  5 / rf_wdata0, rf_wdata1  out  32  write address/data

## Operation
- State: 32-bit FP busy vector, outstanding counter (0..MAX_OUT), age counter (0..AGE_LIMIT).
- Pair index = idx + 1 modulo 32 (5-bit wrap; 31 pairs with 0).
- Hazard: ins_valid and any referenced FP register busy: FP sources (plus pair if ins_src_dbl), FP destination (plus pair if ins_double). Integer registers never hazard.
- Full: ins_valid & ins_long & outstanding == MAX_OUT.
- Fast request: ins_valid & ins_regwrite & ~ins_long & ~hazard.
- Arbitration (guard compiled in): fast wins unless fpu_valid & age == AGE_LIMIT; then FPU wins.
- stall = hazard | full | (fast request lost arbitration).
- Long issue accepted when ins_valid & ins_long & ~stall: sets busy[dst] (and pair if double), outstanding +1.
- FPU accept (fpu_ready): drives rf_* from fpu_* with rf_fp=1; clears busy[fpu_dst] (and pair), outstanding -1, age <- 0.
- Age: +1 (saturating) each cycle fpu_valid & ~fpu_ready.
- Same-cycle accept and long issue: both counter updates apply (net 0); busy set and clear apply to their own bits. Hazard uses pre-edge busy: reading a register being completed this cycle stalls one cycle (no forwarding).
- rf_we=0 when neither source granted; rf_waddr/data then don't-care (drive 0).

## Timing
- Arbitration, stall, fpu_ready, rf_* combinational same cycle; register file commits at next clk edge.
- Busy, outstanding, age update at clk edge.
- rst asserted: busy=0, outstanding=0, age=0 immediately; while asserted rf_we=0, fpu_ready=0, stall=1.
- Reset mid-operation drops in-flight completions; FPU must be reset on the same rst.
- Completion for a non-busy destination: still written, busy unaffected, outstanding not decremented below 0 (protocol error; flagged in simulation).

## Configuration
- REGWB_AGE_GUARD_EN defined: fast-priority arbitration with age counter and AGE_LIMIT as above.
- Undefined: no age counter; FPU completion always wins, fast request loses (stall) whenever fpu_valid; AGE_LIMIT unused.

## Structure
- regwb_pkg: writeback request struct (we, fp, double, addr, data0, data1), pair-index function, MAX_OUT range constant.
- Sub-module regwb_scoreboard: busy vector, outstanding counter, hazard/full evaluation; top holds arbiter and age counter.

## Test plan
- Reset: after rst, busy=0, issue ADD.S f2 short -> rf_we=1, rf_fp=1, rf_waddr=2, stall=0.
- Long double to f30 then read f31 -> stall=1 until fpu_valid dst=30 double accepted; stall drops cycle after accept.
- Wrap: long double to f31 marks f31 and f0; integer read of r0 not stalled, FP read of f0 stalled.
- MAX_OUT=4: five back-to-back long issues -> fifth stalls until first completion accepted.
- Guard on, AGE_LIMIT=3, fast writes every cycle, fpu_valid held -> fpu_ready on 4th cycle, stall=1 that cycle.
- Guard off, fpu_valid with fast write same cycle -> fpu_ready=1, stall=1, rf_waddr=fpu_dst.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared types for the register-file write-port scheduler: the writeback request
// record, the FP pair-index helper and the outstanding-counter sizing.
package regwb_pkg;

  localparam int MAX_OUT_LIMIT = 15;
  localparam int OUT_W = $clog2(MAX_OUT_LIMIT + 1);

  typedef struct packed {
    logic        we;
    logic        fp;
    logic        dbl;
    logic [4:0]  addr;
    logic [31:0] data0;
    logic [31:0] data1;
  } wb_req_t;

  // Second register of a pair; f31 pairs with f0.
  function automatic logic [4:0] pair_idx(input logic [4:0] idx);
    return idx + 5'd1;
  endfunction

endpackage

// File: rtl/regwb_scheduler_if.sv
// Core / FPU / register-file signal bundle of regwb_scheduler; master is the
// surrounding datapath, slave is the scheduler.
interface regwb_scheduler_if;
  logic        ins_valid;
  logic        ins_regwrite;
  logic        ins_long;
  logic        ins_fp;
  logic        ins_double;
  logic [4:0]  ins_dst;
  logic [4:0]  ins_src0;
  logic [4:0]  ins_src1;
  logic        ins_src_fp0;
  logic        ins_src_fp1;
  logic        ins_src_dbl;
  logic [31:0] ins_wdata0;
  logic [31:0] ins_wdata1;
  logic        fpu_valid;
  logic [4:0]  fpu_dst;
  logic        fpu_double;
  logic [31:0] fpu_data0;
  logic [31:0] fpu_data1;
  logic        fpu_ready;
  logic        stall;
  logic        rf_we;
  logic        rf_fp;
  logic        rf_double;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata0;
  logic [31:0] rf_wdata1;

  modport master (
    output ins_valid, ins_regwrite, ins_long, ins_fp, ins_double,
           ins_dst, ins_src0, ins_src1, ins_src_fp0, ins_src_fp1, ins_src_dbl,
           ins_wdata0, ins_wdata1,
           fpu_valid, fpu_dst, fpu_double, fpu_data0, fpu_data1,
    input  fpu_ready, stall, rf_we, rf_fp, rf_double, rf_waddr, rf_wdata0, rf_wdata1
  );

  modport slave (
    input  ins_valid, ins_regwrite, ins_long, ins_fp, ins_double,
           ins_dst, ins_src0, ins_src1, ins_src_fp0, ins_src_fp1, ins_src_dbl,
           ins_wdata0, ins_wdata1,
           fpu_valid, fpu_dst, fpu_double, fpu_data0, fpu_data1,
    output fpu_ready, stall, rf_we, rf_fp, rf_double, rf_waddr, rf_wdata0, rf_wdata1
  );
endinterface

// File: rtl/regwb_scoreboard.sv
// FP scoreboard: busy bit per FP register with an outstanding long-op counter;
// evaluates RAW/WAW hazard and the full condition from pre-edge state.
module regwb_scoreboard
  import regwb_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ins_valid,
  input  logic       ins_regwrite,
  input  logic       ins_long,
  input  logic       ins_fp,
  input  logic       ins_double,
  input  logic [4:0] ins_dst,
  input  logic [4:0] ins_src0,
  input  logic [4:0] ins_src1,
  input  logic       ins_src_fp0,
  input  logic       ins_src_fp1,
  input  logic       ins_src_dbl,
  input  logic       issue,
  input  logic       clear,
  input  logic [4:0] clr_dst,
  input  logic       clr_double,
  output logic       hazard,
  output logic       full
);

  if (MAX_OUT < 1 || MAX_OUT > MAX_OUT_LIMIT) begin : g_bad_max_out
    $error("regwb_scoreboard: MAX_OUT must be within 1..15");
  end

  function automatic logic [31:0] reg_mask(input logic [4:0] idx, input logic dbl);
    logic [31:0] m;
    m = '0;
    m[idx] = 1'b1;
    if (dbl) m[pair_idx(idx)] = 1'b1;
    return m;
  endfunction

  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [OUT_W-1:0] out_q;
  logic             src0_hz;
  logic             src1_hz;
  logic             dst_hz;
  logic             dec;

  assign src0_hz = ins_src_fp0 & (|(busy_q & reg_mask(ins_src0, ins_src_dbl)));
  assign src1_hz = ins_src_fp1 & (|(busy_q & reg_mask(ins_src1, ins_src_dbl)));
  assign dst_hz  = ins_fp & (ins_regwrite | ins_long) & (|(busy_q & reg_mask(ins_dst, ins_double)));
  assign hazard  = ins_valid & (src0_hz | src1_hz | dst_hz);
  assign full    = ins_valid & ins_long & (out_q == OUT_W'(MAX_OUT));

  // A stray completion must never wrap the counter below zero.
  assign dec = clear & (out_q != '0);

  always_comb begin
    busy_d = busy_q;
    if (clear) busy_d = busy_d & ~reg_mask(clr_dst, clr_double);
    if (issue) busy_d = busy_d | reg_mask(ins_dst, ins_double);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      out_q  <= '0;
    end else begin
      busy_q <= busy_d;
      case ({issue, dec})
        2'b10:   out_q <= out_q + OUT_W'(1);
        2'b01:   out_q <= out_q - OUT_W'(1);
        default: out_q <= out_q;
      endcase
      if (clear) begin
        assert (busy_q[clr_dst])
          else $warning("regwb_scoreboard: completion for idle destination %0d", clr_dst);
      end
    end
  end

endmodule

// File: rtl/regwb_scheduler.sv
// Register-file write-port arbiter between single-cycle core results and FPU
// completions, with FP scoreboard stalls. Optional macro: REGWB_AGE_GUARD_EN.
module regwb_scheduler
  import regwb_pkg::*;
#(
  parameter int MAX_OUT   = 4,
  parameter int AGE_LIMIT = 3
) (
  input logic              clk,
  input logic              rst,
  regwb_scheduler_if.slave bus
);

  if (AGE_LIMIT < 1) begin : g_bad_age_limit
    $error("regwb_scheduler: AGE_LIMIT must be at least 1");
  end

  logic    hazard;
  logic    full;
  logic    fast_req;
  logic    fpu_wins;
  logic    accept;
  logic    fast_grant;
  logic    issue;
  wb_req_t wb;

  regwb_scoreboard #(
    .MAX_OUT (MAX_OUT)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (bus.ins_valid),
    .ins_regwrite (bus.ins_regwrite),
    .ins_long     (bus.ins_long),
    .ins_fp       (bus.ins_fp),
    .ins_double   (bus.ins_double),
    .ins_dst      (bus.ins_dst),
    .ins_src0     (bus.ins_src0),
    .ins_src1     (bus.ins_src1),
    .ins_src_fp0  (bus.ins_src_fp0),
    .ins_src_fp1  (bus.ins_src_fp1),
    .ins_src_dbl  (bus.ins_src_dbl),
    .issue        (issue),
    .clear        (accept),
    .clr_dst      (bus.fpu_dst),
    .clr_double   (bus.fpu_double),
    .hazard       (hazard),
    .full         (full)
  );

  assign fast_req = bus.ins_valid & bus.ins_regwrite & ~bus.ins_long & ~hazard;

`ifdef REGWB_AGE_GUARD_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q;
  logic             age_hit;

  // The core keeps priority until a waiting completion has lost AGE_LIMIT times.
  assign age_hit  = (age_q == AGE_W'(AGE_LIMIT));
  assign fpu_wins = bus.fpu_valid & (~fast_req | age_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else if (accept) begin
      age_q <= '0;
    end else if (bus.fpu_valid && !age_hit) begin
      age_q <= age_q + AGE_W'(1);
    end
  end
`else
  assign fpu_wins = bus.fpu_valid;
`endif

  assign accept     = fpu_wins & ~rst;
  assign fast_grant = fast_req & ~fpu_wins & ~rst;
  assign bus.stall  = rst | hazard | full | (fast_req & fpu_wins);
  assign issue      = bus.ins_valid & bus.ins_long & ~bus.stall;

  always_comb begin
    wb = '0;
    if (accept) begin
      wb.we    = 1'b1;
      wb.fp    = 1'b1;
      wb.dbl   = bus.fpu_double;
      wb.addr  = bus.fpu_dst;
      wb.data0 = bus.fpu_data0;
      wb.data1 = bus.fpu_data1;
    end else if (fast_grant) begin
      wb.we    = 1'b1;
      wb.fp    = bus.ins_fp;
      wb.dbl   = bus.ins_double;
      wb.addr  = bus.ins_dst;
      wb.data0 = bus.ins_wdata0;
      wb.data1 = bus.ins_wdata1;
    end
  end

  assign bus.fpu_ready = accept;
  assign bus.rf_we     = wb.we;
  assign bus.rf_fp     = wb.fp;
  assign bus.rf_double = wb.dbl;
  assign bus.rf_waddr  = wb.addr;
  assign bus.rf_wdata0 = wb.data0;
  assign bus.rf_wdata1 = wb.data1;

endmodule
